// File: rtl/inst_rbus_responder_pkg.sv
// Shared definitions for the instruction read-bus responder:
// cache block size, derived block word count and FSM state encoding.
package inst_rbus_responder_pkg;

  localparam int CACHE_BLK_SIZE = 128;
  localparam int BLK_WORDS_DEF = CACHE_BLK_SIZE / 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } rbus_state_e;

endpackage

// File: rtl/inst_rbus_responder.sv
// Instruction read-bus responder: accepts one-cycle block reads,
// fetches BLK_WORDS words from a sync word RAM, returns the block.
// Ports: cpu_clk/cpu_rst (async, active-high), cpu_ren/cpu_raddr
// request; dev_rrdy/dev_rvalid/dev_rdata response; mem_en/mem_addr/
// mem_rdata instruction RAM (data valid one cycle after mem_en).
module inst_rbus_responder
  import inst_rbus_responder_pkg::*;
#(
  parameter int BLK_WORDS   = BLK_WORDS_DEF,
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int ALIGN_BLK   = 1
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rst,
  input  logic [3:0]              cpu_ren,
  input  logic [31:0]             cpu_raddr,
  output logic                    dev_rrdy,
  output logic                    dev_rvalid,
  output logic [BLK_WORDS*32-1:0] dev_rdata,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [31:0]             mem_rdata
);

  localparam int CNT_W =
    (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int WC_W =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BLK_WORDS - 1);
  localparam logic [ADDR_W-1:0] AMASK =
    (ALIGN_BLK != 0) ? ~ADDR_W'(BLK_WORDS - 1) : '1;

  rbus_state_e        state;
  logic [ADDR_W-1:0]  base;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   cap_cnt;
  logic [WC_W-1:0]    wait_cnt;
  logic               rd_vld;
  logic [31:0]        line_buf [BLK_WORDS];

  logic [ADDR_W-1:0]  req_base;
  logic               accept;
  logic               unused_addr;

  assign req_base = cpu_raddr[ADDR_W+1:2] & AMASK;
  assign accept = dev_rrdy && (cpu_ren != 4'h0);
  assign unused_addr =
    ^{cpu_raddr[31:ADDR_W+2], cpu_raddr[1:0]};

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= IDLE;
      base       <= '0;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      wait_cnt   <= '0;
      rd_vld     <= 1'b0;
      dev_rrdy   <= 1'b0;
      dev_rvalid <= 1'b0;
      dev_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      for (int i = 0; i < BLK_WORDS; i++)
        line_buf[i] <= '0;
    end else begin
      // RAM returns data the cycle after it samples mem_en
      rd_vld     <= mem_en;
      dev_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base     <= req_base;
            dev_rrdy <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WC_W'(WAIT_CYCLES);
            end else begin
              state     <= FETCH;
              mem_en    <= 1'b1;
              mem_addr  <= req_base;
              issue_cnt <= '0;
              cap_cnt   <= '0;
            end
          end else begin
            dev_rrdy <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt <= WC_W'(1)) begin
            wait_cnt  <= '0;
            state     <= FETCH;
            mem_en    <= 1'b1;
            mem_addr  <= base;
            issue_cnt <= '0;
            cap_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        FETCH: begin
          if (mem_en) begin
            if (issue_cnt == LAST) begin
              mem_en <= 1'b0;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
              mem_addr  <= mem_addr + 1'b1;
            end
          end
          if (rd_vld) begin
            if (cap_cnt == LAST) begin
              // publish whole block at once; last word
              // comes straight from the RAM
              for (int i = 0; i < BLK_WORDS; i++)
                dev_rdata[i*32 +: 32] <=
                  (i == BLK_WORDS - 1) ?
                  mem_rdata : line_buf[i];
              state      <= RESP;
              dev_rvalid <= 1'b1;
            end else begin
              line_buf[cap_cnt] <= mem_rdata;
              cap_cnt <= cap_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          dev_rrdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rbus_responder.sv
// Directed bench for inst_rbus_responder: aligned, uncached,
// wrap, busy-drop/back-to-back, wait stretch, reset mid-fetch.
module tb_inst_rbus_responder;

  logic         clk;
  logic         cpu_rst;
  logic [3:0]   ren   [3];
  logic [31:0]  raddr [3];
  logic         rrdy  [3];
  logic         rv    [3];
  logic [127:0] rdat  [3];
  logic         men   [3];
  logic [13:0]  maddr [3];
  logic [31:0]  mrd   [3];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [13:0]  mlog  [3][16];
  int           mcnt  [3];
  int           mfirst[3];
  int           rv_cnt[3];
  int           rv_cyc[3];
  logic [127:0] rv_dat[3];

  // 0: aligned, 1: uncached, 2: aligned with wait stretch
  inst_rbus_responder #(.ALIGN_BLK(1), .WAIT_CYCLES(0)) u_al (
    .cpu_clk(clk), .cpu_rst(cpu_rst),
    .cpu_ren(ren[0]), .cpu_raddr(raddr[0]),
    .dev_rrdy(rrdy[0]), .dev_rvalid(rv[0]),
    .dev_rdata(rdat[0]), .mem_en(men[0]),
    .mem_addr(maddr[0]), .mem_rdata(mrd[0])
  );

  inst_rbus_responder #(.ALIGN_BLK(0), .WAIT_CYCLES(0)) u_un (
    .cpu_clk(clk), .cpu_rst(cpu_rst),
    .cpu_ren(ren[1]), .cpu_raddr(raddr[1]),
    .dev_rrdy(rrdy[1]), .dev_rvalid(rv[1]),
    .dev_rdata(rdat[1]), .mem_en(men[1]),
    .mem_addr(maddr[1]), .mem_rdata(mrd[1])
  );

  inst_rbus_responder #(.ALIGN_BLK(1), .WAIT_CYCLES(3)) u_wt (
    .cpu_clk(clk), .cpu_rst(cpu_rst),
    .cpu_ren(ren[2]), .cpu_raddr(raddr[2]),
    .dev_rrdy(rrdy[2]), .dev_rvalid(rv[2]),
    .dev_rdata(rdat[2]), .mem_en(men[2]),
    .mem_addr(maddr[2]), .mem_rdata(mrd[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // word k of memory holds 0x1000_0000 + k
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (men[i])
        mrd[i] <= 32'h1000_0000 + {18'b0, maddr[i]};

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (men[i]) begin
        if (mcnt[i] == 0) mfirst[i] = cyc;
        if (mcnt[i] < 16) mlog[i][mcnt[i]] = maddr[i];
        mcnt[i]++;
      end
      if (rv[i]) begin
        rv_cnt[i]++;
        rv_cyc[i] = cyc;
        rv_dat[i] = rdat[i];
      end
    end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic clr(input int i);
    mcnt[i] = 0;
    mfirst[i] = -1;
    rv_cnt[i] = 0;
    rv_cyc[i] = -1;
  endtask

  task automatic go(input int i, input logic [31:0] a,
                    output int e0);
    @(negedge clk);
    clr(i);
    raddr[i] = a;
    ren[i] = 4'hF;
    @(posedge clk);
    #1;
    e0 = cyc;
    ren[i] = 4'h0;
  endtask

  task automatic wait_rv(input int i, input string tag);
    for (int k = 0; k < 40 && rv_cnt[i] == 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_rv_seen"}, 128'(rv_cnt[i] != 0), 128'(1));
  endtask

  task automatic chk_addrs(input int i, input string tag,
                           input logic [13:0] a0,
                           input logic [13:0] a1,
                           input logic [13:0] a2,
                           input logic [13:0] a3);
    chk({tag, "_men_cnt"}, 128'(mcnt[i]), 128'(4));
    chk({tag, "_addr0"}, 128'(mlog[i][0]), 128'(a0));
    chk({tag, "_addr1"}, 128'(mlog[i][1]), 128'(a1));
    chk({tag, "_addr2"}, 128'(mlog[i][2]), 128'(a2));
    chk({tag, "_addr3"}, 128'(mlog[i][3]), 128'(a3));
  endtask

  initial begin
    int e0, e1;
    cpu_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ren[i] = 4'h0;
      raddr[i] = 32'h0;
      clr(i);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rrdy", 128'(rrdy[0]), 128'(0));
    chk("rst_rvalid", 128'(rv[0]), 128'(0));
    chk("rst_rdata", rdat[0], 128'(0));
    chk("rst_mem_en", 128'(men[0]), 128'(0));
    chk("rst_mem_addr", 128'(maddr[0]), 128'(0));
    @(negedge clk);
    cpu_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rrdy_after_rst", 128'(rrdy[0]), 128'(1));

    // aligned fetch
    go(0, 32'h0000_0048, e0);
    chk("al_rrdy_busy", 128'(rrdy[0]), 128'(0));
    wait_rv(0, "al");
    chk_addrs(0, "al", 14'h10, 14'h11, 14'h12, 14'h13);
    chk("al_latency", 128'(rv_cyc[0] - e0), 128'(5));
    chk("al_rdata", rv_dat[0],
        128'h10000013_10000012_10000011_10000010);
    chk("al_rrdy_in_resp", 128'(rrdy[0]), 128'(0));
    @(posedge clk);
    #1;
    chk("al_rrdy_back", 128'(rrdy[0]), 128'(1));
    chk("al_rrdy_edge", 128'(cyc - e0), 128'(6));

    // uncached order
    go(1, 32'h0000_0048, e0);
    wait_rv(1, "un");
    chk_addrs(1, "un", 14'h12, 14'h13, 14'h14, 14'h15);
    chk("un_lane0", 128'(rv_dat[1][31:0]), 128'h10000012);
    chk("un_rdata", rv_dat[1],
        128'h10000015_10000014_10000013_10000012);
    chk("un_latency", 128'(rv_cyc[1] - e0), 128'(5));

    // top-of-memory wrap
    go(1, 32'h0000_FFF8, e0);
    wait_rv(1, "wr");
    chk_addrs(1, "wr", 14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001);
    chk("wr_rdata", rv_dat[1],
        128'h10000001_10000000_10003FFF_10003FFE);

    // busy drop then back-to-back
    go(0, 32'h0000_0048, e0);
    @(negedge clk);
    @(negedge clk);
    raddr[0] = 32'h0000_0100;
    ren[0] = 4'hF;
    @(posedge clk);
    #1;
    ren[0] = 4'h0;
    wait_rv(0, "bz");
    chk("bz_men_cnt", 128'(mcnt[0]), 128'(4));
    chk("bz_rdata", rv_dat[0],
        128'h10000013_10000012_10000011_10000010);
    go(0, 32'h0000_0080, e1);
    chk("b2b_accept_edge", 128'(e1 - e0), 128'(7));
    wait_rv(0, "b2b");
    chk("b2b_rdata", rv_dat[0],
        128'h10000023_10000022_10000021_10000020);
    repeat (10) @(negedge clk);
    #1;
    chk("b2b_rv_pulses", 128'(rv_cnt[0]), 128'(1));
    chk("b2b_men_cnt", 128'(mcnt[0]), 128'(4));
    chk("b2b_rdata_hold", rdat[0],
        128'h10000023_10000022_10000021_10000020);

    // wait stretch
    go(2, 32'h0000_0048, e0);
    wait_rv(2, "wt");
    chk("wt_first_rd_edge", 128'(mfirst[2] - e0 + 1), 128'(4));
    chk("wt_latency", 128'(rv_cyc[2] - e0), 128'(8));
    chk("wt_rdata", rv_dat[2],
        128'h10000013_10000012_10000011_10000010);

    // reset mid-fetch
    go(0, 32'h0000_0048, e0);
    @(negedge clk);
    @(negedge clk);
    #2;
    cpu_rst = 1'b1;
    #1;
    chk("mr_pre_men_cnt", 128'(mcnt[0]), 128'(2));
    chk("mr_rrdy", 128'(rrdy[0]), 128'(0));
    chk("mr_rvalid", 128'(rv[0]), 128'(0));
    chk("mr_rdata", rdat[0], 128'(0));
    chk("mr_mem_en", 128'(men[0]), 128'(0));
    chk("mr_mem_addr", 128'(maddr[0]), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    cpu_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_rrdy_release", 128'(rrdy[0]), 128'(1));
    repeat (6) @(negedge clk);
    #1;
    chk("mr_no_rvalid", 128'(rv_cnt[0]), 128'(0));
    chk("mr_men_stopped", 128'(mcnt[0]), 128'(2));
    go(0, 32'h0000_0030, e0);
    wait_rv(0, "mr_new");
    chk_addrs(0, "mr_new", 14'h0C, 14'h0D, 14'h0E, 14'h0F);
    chk("mr_new_rdata", rv_dat[0],
        128'h1000000F_1000000E_1000000D_1000000C);
    chk("mr_new_latency", 128'(rv_cyc[0] - e0), 128'(5));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
